// File: rtl/tick_pkg.sv
// Shared time-base helpers and repeat FSM state encoding for tick_scheduler.
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Bits needed for a counter spanning 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_repeat_fsm.sv
// Press-and-hold auto-repeat: pulse on press, again after a hold delay, then periodically.
module tick_repeat_fsm
  import tick_pkg::*;
#(
  parameter int unsigned DELAY_TICKS  = 500,
  parameter int unsigned PERIOD_TICKS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic set_hold,
  output logic repeat_tick
);

  localparam int unsigned MAX_TICKS = (DELAY_TICKS > PERIOD_TICKS) ? DELAY_TICKS : PERIOD_TICKS;
  localparam int unsigned CW = cnt_w(MAX_TICKS);

  rpt_state_t     state;
  logic [CW-1:0]  cnt;
  logic           hold_q;
  logic           rise;
  logic           delay_done;
  logic           period_done;

  assign rise        = set_hold & ~hold_q;
  assign delay_done  = tick && (cnt == CW'(DELAY_TICKS - 1));
  assign period_done = tick && (cnt == CW'(PERIOD_TICKS - 1));

  always_comb begin
    repeat_tick = 1'b0;
    unique case (state)
      IDLE:    repeat_tick = rise;
      DELAY:   repeat_tick = set_hold && delay_done;
      REPEAT:  repeat_tick = set_hold && period_done;
      default: repeat_tick = 1'b0;
    endcase
  end

  // hold_q resets high so a button already held at reset release needs a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hold_q <= 1'b1;
    end else begin
      hold_q <= set_hold;
      if (!set_hold) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state <= DELAY;
              cnt   <= '0;
            end
          end
          DELAY: begin
            if (delay_done) begin
              state <= REPEAT;
              cnt   <= '0;
            end else if (tick) begin
              cnt <= cnt + CW'(1);
            end
          end
          REPEAT: begin
            if (period_done) cnt <= '0;
            else if (tick)   cnt <= cnt + CW'(1);
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Central time base: shared scan prescaler, pausable seconds tick, blink level, button auto-repeat.
// Optional crystal trim of the last millisecond per second when TICK_SCHED_CAL_EN is defined.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned SCAN_HZ          = 1000,
  parameter int unsigned BLINK_HALF_MS    = 500,
  parameter int unsigned REPEAT_DELAY_MS  = 500,
  parameter int unsigned REPEAT_PERIOD_MS = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              resync,
  input  logic              set_hold,
`ifdef TICK_SCHED_CAL_EN
  input  logic signed [7:0] cal_trim,
`endif
  output logic              scan_tick,
  output logic              sec_tick,
  output logic              blink,
  output logic              repeat_tick,
  output logic              paused
);

  localparam int unsigned DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned PW  = cnt_w(DIV);
  localparam int unsigned MW  = cnt_w(SCAN_HZ);
  localparam int unsigned BW  = cnt_w(BLINK_HALF_MS);
`ifdef TICK_SCHED_CAL_EN
  localparam int unsigned SW  = cnt_w(DIV + 128);
`else
  localparam int unsigned SW  = PW;
`endif

  logic [PW-1:0] pre;
  logic [SW-1:0] sub;
  logic [SW-1:0] sub_last;
  logic [MW-1:0] ms;
  logic [BW-1:0] blink_cnt;
  logic          ms_last;
  logic          sub_wrap;

  assign scan_tick = (pre == PW'(DIV - 1));
  assign ms_last   = (ms == MW'(SCAN_HZ - 1));
  assign sub_wrap  = run_en && (sub == sub_last);
  assign sec_tick  = sub_wrap && ms_last && !resync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre <= '0;
    else      pre <= scan_tick ? '0 : pre + PW'(1);
  end

`ifdef TICK_SCHED_CAL_EN
  logic signed [7:0] trim_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          trim_q <= '0;
    else if (sec_tick) trim_q <= cal_trim;
  end

  // Sign-extending cast; modular add gives DIV-1+trim for the final millisecond.
  assign sub_last = ms_last ? (SW'(DIV - 1) + SW'(trim_q)) : SW'(DIV - 1);
`else
  assign sub_last = SW'(DIV - 1);
`endif

  // Seconds path keeps its own sub-ms phase so resync never disturbs scan_tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub    <= '0;
      ms     <= '0;
      paused <= 1'b1;
    end else begin
      paused <= ~run_en;
      if (resync) begin
        sub <= '0;
        ms  <= '0;
      end else if (run_en) begin
        if (sub_wrap) begin
          sub <= '0;
          ms  <= ms_last ? '0 : ms + MW'(1);
        end else begin
          sub <= sub + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (scan_tick) begin
      if (blink_cnt == BW'(BLINK_HALF_MS - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  tick_repeat_fsm #(
    .DELAY_TICKS  (REPEAT_DELAY_MS),
    .PERIOD_TICKS (REPEAT_PERIOD_MS)
  ) u_repeat (
    .clk         (clk),
    .rst         (rst),
    .tick        (scan_tick),
    .set_hold    (set_hold),
    .repeat_tick (repeat_tick)
  );

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler at CLK_HZ=10_000, SCAN_HZ=1000 (DIV=10, 1 s = 10_000 cycles).
module tb_tick_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run_en = 1'b1;
  logic resync = 1'b0;
  logic set_hold = 1'b0;
  logic scan_tick, sec_tick, blink, repeat_tick, paused;
`ifdef TICK_SCHED_CAL_EN
  logic signed [7:0] cal_trim = '0;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_scan = 0;
  int n_bad_scan = 0;
  int s0, s1;
  logic blink_prev = 1'b0;
  int sec_q[$];
  int rpt_q[$];
  int blk_q[$];

  int exp_sec[5] = '{9999, 19999, 32999, 44321, 64321};
  int exp_rpt[8] = '{36000, 40999, 41999, 42999, 43999, 44999, 45999, 47000};

  always #5 clk = ~clk;

  tick_scheduler #(
    .CLK_HZ           (10_000),
    .SCAN_HZ          (1000),
    .BLINK_HALF_MS    (500),
    .REPEAT_DELAY_MS  (500),
    .REPEAT_PERIOD_MS (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_en      (run_en),
    .resync      (resync),
    .set_hold    (set_hold),
`ifdef TICK_SCHED_CAL_EN
    .cal_trim    (cal_trim),
`endif
    .scan_tick   (scan_tick),
    .sec_tick    (sec_tick),
    .blink       (blink),
    .repeat_tick (repeat_tick),
    .paused      (paused)
  );

  // Cycle index since reset release; equals the prescaler phase.
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (rst) begin
      if (scan_tick) begin
        n_scan++;
        if (cyc % 10 != 9) n_bad_scan++;
      end
      if (sec_tick)      sec_q.push_back(cyc);
      if (repeat_tick)   rpt_q.push_back(cyc);
      if (blink != blink_prev) blk_q.push_back(cyc);
    end
    blink_prev = blink;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_scan_tick", int'(scan_tick), 0);
    check("rst_sec_tick", int'(sec_tick), 0);
    check("rst_blink", int'(blink), 0);
    check("rst_repeat_tick", int'(repeat_tick), 0);
    check("rst_paused", int'(paused), 1);

    @(posedge clk);
    #1;
    rst = 1'b1;
    check("paused_cycle0", int'(paused), 1);
    goto(1);
    check("paused_cycle1", int'(paused), 0);

    goto(25000);
    run_en = 1'b0;
    s0 = n_scan;
    check("paused_latency", int'(paused), 0);
    goto(25001);
    check("paused_on", int'(paused), 1);
    goto(26500);
    check("sec_frozen", int'(sec_tick), 0);
    goto(28000);
    run_en = 1'b1;
    s1 = n_scan;
    check("scan_during_pause", s1 - s0, 300);
    check("paused_still", int'(paused), 1);
    goto(28001);
    check("paused_off", int'(paused), 0);

    goto(34321);
    resync = 1'b1;
    goto(34322);
    resync = 1'b0;

    goto(36000);
    set_hold = 1'b1;
    goto(46000);
    set_hold = 1'b0;
    goto(47000);
    set_hold = 1'b1;
    goto(47005);
    set_hold = 1'b0;

    goto(54321);
    resync = 1'b1;
    goto(54322);
    resync = 1'b0;

    goto(66000);
    check("scan_total", n_scan, 6600);
    check("sec_count", sec_q.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("sec_at_%0d", i), sec_q[i], exp_sec[i]);
    check("rpt_count", rpt_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("rpt_at_%0d", i), rpt_q[i], exp_rpt[i]);
    check("blink_toggles", blk_q.size(), 13);
    for (int i = 0; i < 13; i++) check($sformatf("blink_at_%0d", i), blk_q[i], 5000 * (i + 1));
    check("blink_before_reset", int'(blink), 1);

    set_hold = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_blink", int'(blink), 0);
    check("async_paused", int'(paused), 1);
    check("async_scan_tick", int'(scan_tick), 0);
    check("async_repeat_tick", int'(repeat_tick), 0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    goto(6000);
    check("held_through_reset", rpt_q.size(), 8);
    set_hold = 1'b0;
    goto(6010);
    set_hold = 1'b1;
    goto(6020);
    set_hold = 1'b0;
    check("repress_count", rpt_q.size(), 9);
    check("repress_at", rpt_q[8], 6010);
    check("blink_after_reset_count", blk_q.size(), 14);
    check("blink_after_reset_at", blk_q[13], 5000);
    check("scan_cadence", n_bad_scan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
